score_hex_ctrl: RTL and testbench
=================================

// Module: score_hex_ctrl
// PURPOSE
//  Sequences the DE1-SoC seven-segment digits for the game score. Accepts a
//  binary score on a load strobe and converts it to BCD serially (double-dabble).
//  The conversion takes one bit per cycle. The block then commits all digits
//  at once to a display register that drives per-digit seg7 decoders.
//  It sits between game logic (score counter) and the HEX0..HEXn board pins.
// PARAMETERS
//  BIN_W     10  width of binary score input (bits)
//  N_DIGITS  4   number of HEX digits driven; digit 0 = least significant
// PORTS
//  clk        in   1             system clock; single clock domain
//  reset      in   1             synchronous, active-high
//  value      in   BIN_W         binary score, sampled only on accepted load
//  load       in   1             request conversion; accepted only when busy=0
//  busy       out  1             conversion in progress; load ignored
//  done       out  1             1-cycle pulse; display register updated this cycle
//  overflow   out  1             last committed value >= 10**N_DIGITS (sticky to next commit)
//  hex_leds   out  N_DIGITS x 7  active-low segment patterns, [i] drives HEXi
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, overflow=0, display BCD register=0
//    (all digits show "0", i.e. 7'b1000000). Reset mid-conversion aborts and
//    clears the display register; no done pulse.
//  - FSM IDLE -> SHIFT -> COMMIT -> IDLE.
//    IDLE: load=1 captures value into shift reg, clears BCD scratch
//      (4*N_DIGITS bits), bit counter=BIN_W, busy=1 next cycle.
//    SHIFT: each cycle, for every nibble >=5 add 3 (all nibbles in parallel),
//      then shift {bcd,bin} left 1. Counter decrements; after BIN_W
//      shifts go to COMMIT.
//    COMMIT: copy scratch (or saturated value) to display register. done=1
//      and busy=0 in this state. Return to IDLE. A load seen in COMMIT is ignored.
//  - Latency: load accepted at cycle 0 -> done=1 and new hex_leds at cycle BIN_W+1.
//    Back-to-back accepted loads are spaced BIN_W+2 cycles apart.
//  - Load while busy (SHIFT/COMMIT): dropped, no queue, no error flag.
//  - Saturation: the overflow check compares the captured value against the
//    10**N_DIGITS constant. If the value is >= that constant, commit all 9s
//    and set overflow=1. Otherwise commit the BCD result and set overflow=0.
//  - Digits map to hex_leds via combinational seg7 decode of the display
//    register. Outputs change only in COMMIT or reset, never mid-conversion.
// CONFIGURATION
//  HEX_BLANK_EN defined: leading-zero blanking applies. Any digit i>0 whose
//    value and all higher digits are 0 outputs 7'h7F (segments off).
//    Digit 0 is always shown. Saturated 9s are never blanked.
//  HEX_BLANK_EN undefined: every digit always shows its decoded value,
//    including leading zeros.
// STRUCTURE
//  Package score_hex_pkg:
//    - state enum type (IDLE, SHIFT, COMMIT)
//    - SEG_BLANK = 7'h7F
//    - function pow10(n) used for the saturation limit
//  Sub-module: existing seg7 decoder, one instance per digit (generate loop).
//  The FSM, double-dabble datapath and display register live in this module.
// TESTING
//  1 reset; value=1234, load 1 cycle (BIN_W=11, N=4) -> done at cycle 12;
//    hex_leds[3..0]=1,2,3,4 = 1111001,0100100,0110000,0011001; overflow=0.
//  2 value=0, load -> all digits 1000000 (no HEX_BLANK_EN);
//    with HEX_BLANK_EN: [3..1]=1111111, [0]=1000000.
//  3 N_DIGITS=3, BIN_W=10, value=1000, load -> all digits 0010000 (9);
//    overflow=1. Next load value=5 -> overflow=0.
//  4 load value=42, then at cycle 3 load value=99 (busy=1) -> second load
//    ignored; display shows 42; exactly one done pulse.
//  5 load value=777; assert reset at cycle 5 for 1 cycle -> busy=0, no done,
//    all digits 1000000. A new load afterwards converts normally.
//  6 hold load=1 continuously, value=7 -> conversions every BIN_W+2 cycles;
//    hex_leds stable between done pulses.

Source files
------------

// File: rtl/score_hex_pkg.sv
// Shared types and constants for the score seven-segment controller.
package score_hex_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Decimal limit used to detect scores that do not fit the display.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/score_hex_ctrl_seg7.sv
// Active-low seven-segment decoder for one BCD digit, with a blank override.
module score_hex_ctrl_seg7
  import score_hex_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = 7'b1000000;
        4'd1:    seg = 7'b1111001;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_hex_ctrl.sv
// Serial binary-to-BCD (double-dabble) score converter driving HEX digit decoders.
// Optional build macro HEX_BLANK_EN enables leading-zero blanking of digits above 0.
module score_hex_ctrl
  import score_hex_pkg::*;
#(
  parameter int unsigned BIN_W    = 10,
  parameter int unsigned N_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BIN_W-1:0]          value,
  input  logic                      load,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [N_DIGITS-1:0][6:0]  hex_leds
);

  localparam int unsigned BCD_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] LIMIT = pow10(N_DIGITS);

  state_e                 state_q;
  logic [BIN_W-1:0]       bin_q;
  logic [BCD_W-1:0]       bcd_q;
  logic [BCD_W-1:0]       disp_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sat_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   ovf_q;

  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic                   sat_in;
  logic [N_DIGITS-1:0]    blank;

  // One double-dabble step: correct every nibble, then shift the whole pair.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  assign sat_in = (64'(value) >= LIMIT);

  // Display is written on the edge entering StCommit so it is valid alongside done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            bin_q   <= value;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(BIN_W);
            sat_q   <= sat_in;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          {bcd_q, bin_q} <= shifted;
          cnt_q          <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= StCommit;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ovf_q   <= sat_q;
            disp_q  <= sat_q ? {N_DIGITS{4'h9}} : shifted[BIN_W +: BCD_W];
          end
        end
        StCommit: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

`ifdef HEX_BLANK_EN
  logic zero_above;

  // Saturated 9s are non-zero, so they can never be blanked here.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = int'(N_DIGITS) - 1; i > 0; i--) begin
      zero_above = zero_above && (disp_q[4*i +: 4] == 4'h0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    score_hex_ctrl_seg7 u_seg7 (
      .digit (disp_q[4*g +: 4]),
      .blank (blank[g]),
      .seg   (hex_leds[g])
    );
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_score_hex_ctrl.sv
// Scoreboard bench for score_hex_ctrl: two configurations (11b/4 digits, 10b/3 digits).
module tb_score_hex_ctrl;

  localparam int unsigned BW_A = 11;
  localparam int unsigned ND_A = 4;
  localparam int unsigned BW_B = 10;
  localparam int unsigned ND_B = 3;

  typedef logic [3:0][6:0] hex4_t;
  typedef struct packed {
    hex4_t hex;
    logic  ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset_a, load_a, busy_a, done_a, ovf_a;
  logic [BW_A-1:0]       value_a;
  logic [ND_A-1:0][6:0]  hex_a;
  logic                  reset_b, load_b, busy_b, done_b, ovf_b;
  logic [BW_B-1:0]       value_b;
  logic [ND_B-1:0][6:0]  hex_b;

  score_hex_ctrl #(.BIN_W(BW_A), .N_DIGITS(ND_A)) u_dut_a (
    .clk      (clk),
    .reset    (reset_a),
    .value    (value_a),
    .load     (load_a),
    .busy     (busy_a),
    .done     (done_a),
    .overflow (ovf_a),
    .hex_leds (hex_a)
  );

  score_hex_ctrl #(.BIN_W(BW_B), .N_DIGITS(ND_B)) u_dut_b (
    .clk      (clk),
    .reset    (reset_b),
    .value    (value_b),
    .load     (load_b),
    .busy     (busy_b),
    .done     (done_b),
    .overflow (ovf_b),
    .hex_leds (hex_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // dig holds hand-written decimal digits, digit 0 in the low nibble.
  function automatic hex4_t mk_hex(input int n, input logic [15:0] dig);
    hex4_t h;
`ifdef HEX_BLANK_EN
    logic zr;
    zr = 1'b1;
`endif
    h = '0;
    for (int i = n - 1; i >= 0; i--) begin
      h[i] = seg_of(dig[4*i +: 4]);
`ifdef HEX_BLANK_EN
      zr = zr && (dig[4*i +: 4] == 4'd0);
      if (i > 0 && zr) h[i] = 7'h7F;
`endif
    end
    return h;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done_a) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_a_unexpected: got done pulse expected none (hex %0h)", hex_a);
      end else begin
        e = q_a.pop_front();
        chk("hex_a", 64'(hex_a), 64'(e.hex));
        chk("ovf_a", 64'(ovf_a), 64'(e.ovf));
      end
    end
    if (done_b) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_b_unexpected: got done pulse expected none (hex %0h)", hex_b);
      end else begin
        e = q_b.pop_front();
        chk("hex_b", 64'(hex_b), 64'(e.hex[2:0]));
        chk("ovf_b", 64'(ovf_b), 64'(e.ovf));
      end
    end
  end

  // Waits for done with a bound, checking latency and display stability meanwhile.
  task automatic wait_done_a(input int start);
    int n;
    int unstable;
    logic [ND_A-1:0][6:0] prev;
    n = start;
    unstable = 0;
    prev = hex_a;
    while (!done_a && n < 60) begin
      tick();
      n++;
      if (!done_a && hex_a !== prev) unstable++;
    end
    chk("latency_a", 64'(n), 64'(BW_A + 1));
    chk("hex_stable_a", 64'(unstable), 64'd0);
    tick();
    chk("done_pulse_a", 64'(done_a), 64'd0);
  endtask

  task automatic conv_a(input logic [BW_A-1:0] v, input logic [15:0] dig, input logic ovf);
    q_a.push_back('{hex: mk_hex(ND_A, dig), ovf: ovf});
    value_a = v;
    load_a  = 1'b1;
    tick();
    load_a  = 1'b0;
    chk("busy_a", 64'(busy_a), 64'd1);
    wait_done_a(1);
  endtask

  task automatic conv_b(input logic [BW_B-1:0] v, input logic [11:0] dig, input logic ovf);
    int n;
    q_b.push_back('{hex: mk_hex(ND_B, {4'd0, dig}), ovf: ovf});
    value_b = v;
    load_b  = 1'b1;
    tick();
    load_b  = 1'b0;
    n = 1;
    while (!done_b && n < 60) begin
      tick();
      n++;
    end
    chk("latency_b", 64'(n), 64'(BW_B + 1));
    chk("busy_commit_b", 64'(busy_b), 64'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dones [$];
    int unstable;
    logic [ND_A-1:0][6:0] prev;

    reset_a = 1'b1; reset_b = 1'b1;
    load_a  = 1'b0; load_b  = 1'b0;
    value_a = '0;   value_b = '0;
    tick();
    tick();
    reset_a = 1'b0; reset_b = 1'b0;
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_done_a", 64'(done_a), 64'd0);
    chk("rst_ovf_a", 64'(ovf_a), 64'd0);
    chk("rst_hex_a", 64'(hex_a), 64'(mk_hex(ND_A, 16'h0000)));
    chk("rst_hex_b", 64'(hex_b), 64'(mk_hex(ND_B, 16'h0000)));

    // Main function and width boundaries.
    conv_a(11'd1234, 16'h1234, 1'b0);
    conv_a(11'd0,    16'h0000, 1'b0);
    conv_a(11'd2047, 16'h2047, 1'b0);
    conv_a(11'd9,    16'h0009, 1'b0);

    // Saturation on the 3-digit build, including the 999/1000 edge.
    conv_b(10'd1000, 12'h999, 1'b1);
    conv_b(10'd5,    12'h005, 1'b0);
    conv_b(10'd999,  12'h999, 1'b0);
    conv_b(10'd1023, 12'h999, 1'b1);
    conv_b(10'd0,    12'h000, 1'b0);

    // Load while busy is dropped.
    q_a.push_back('{hex: mk_hex(ND_A, 16'h0042), ovf: 1'b0});
    value_a = 11'd42;
    load_a  = 1'b1;
    tick();
    load_a  = 1'b0;
    tick();
    tick();
    value_a = 11'd99;
    load_a  = 1'b1;
    tick();
    load_a  = 1'b0;
    chk("busy_drop_a", 64'(busy_a), 64'd1);
    wait_done_a(4);
    repeat (15) tick();

    // Reset mid-conversion aborts and clears the display.
    value_a = 11'd777;
    load_a  = 1'b1;
    tick();
    load_a  = 1'b0;
    repeat (4) tick();
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    chk("abort_busy_a", 64'(busy_a), 64'd0);
    chk("abort_done_a", 64'(done_a), 64'd0);
    chk("abort_hex_a", 64'(hex_a), 64'(mk_hex(ND_A, 16'h0000)));
    repeat (20) tick();
    conv_a(11'd123, 16'h0123, 1'b0);

    // Continuous load: conversions every BIN_W+2 cycles.
    for (int k = 0; k < 3; k++) q_a.push_back('{hex: mk_hex(ND_A, 16'h0007), ovf: 1'b0});
    value_a  = 11'd7;
    load_a   = 1'b1;
    unstable = 0;
    prev     = hex_a;
    for (int t = 0; t < 39; t++) begin
      tick();
      if (done_a) dones.push_back(t + 1);
      else if (hex_a !== prev) unstable++;
      prev = hex_a;
    end
    load_a = 1'b0;
    chk("cont_done_count", 64'(dones.size()), 64'd3);
    if (dones.size() == 3) begin
      chk("cont_first", 64'(dones[0]), 64'(BW_A + 1));
      chk("cont_space1", 64'(dones[1] - dones[0]), 64'(BW_A + 2));
      chk("cont_space2", 64'(dones[2] - dones[1]), 64'(BW_A + 2));
    end
    chk("cont_stable", 64'(unstable), 64'd0);
    repeat (20) tick();

    chk("queue_a_empty", 64'(q_a.size()), 64'd0);
    chk("queue_b_empty", 64'(q_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
